// File: rtl/loader_pkg.sv
// Shared definitions for uart_word_loader: FSM state encoding and a
// clog2 helper that never returns less than 1 (usable as a port width).
package loader_pkg;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_DONE    = 1'b1
    } state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_word_loader_if.sv
// Word write port from the loader into instruction memory (valid/ready).
interface uart_word_loader_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/loader_idle_timer.sv
// Inter-byte idle counter for uart_word_loader. Counts while a partial word
// is held, restarts on every received byte, and flags expiry once it has
// reached TIMEOUT_CYCLES-1.
module loader_idle_timer
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 104160
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expire
);

    localparam int unsigned CNT_W = clog2_min1(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Idle counter: cleared when no partial word or a byte arrives, saturates at LAST.
    always_ff @(posedge clk) begin
        if (rst || !run || restart) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    assign expire = run && !restart && (cnt == LAST);

endmodule

// File: rtl/uart_word_loader.sv
// Assembles little-endian words from the uart_rx byte stream and writes them
// with incrementing word addresses to instruction memory over a one-entry
// valid/ready holding register. Stops after NUM_WORDS accepted words.
// Optional feature: define UART_LOADER_TIMEOUT_EN to discard a partial word
// after TIMEOUT_CYCLES of inter-byte idle time.
module uart_word_loader
    import loader_pkg::*;
#(
    parameter  int unsigned WORD_BYTES     = 4,
    parameter  int unsigned ADDR_W         = 10,
    parameter  int unsigned NUM_WORDS      = 1024,
    parameter  int unsigned TIMEOUT_CYCLES = 104160,
    localparam int unsigned IDX_W          = clog2_min1(WORD_BYTES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_dv,
    input  logic [7:0]           rx_byte,
    uart_word_loader_if.master   wr,
    output logic [IDX_W-1:0]     byte_idx,
    output logic                 done,
    output logic                 overrun
);

    localparam int unsigned DATA_W = 8 * WORD_BYTES;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            state;
    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] next_word;
    logic              capture;
    logic              complete;
    logic              accept;
    logic              final_accept;
    logic              expire;

`ifdef UART_LOADER_TIMEOUT_EN
    loader_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (byte_idx != '0),
        .restart (rx_dv),
        .expire  (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Partial word with the incoming byte merged into lane byte_idx.
    always_comb begin
        next_word = partial;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (byte_idx == IDX_W'(i)) begin
                next_word[8*i +: 8] = rx_byte;
            end
        end
    end

    assign capture      = (state == S_COLLECT) && rx_dv;
    assign complete     = capture && (byte_idx == LAST_IDX);
    assign accept       = wr.wr_valid && wr.wr_ready;
    assign final_accept = accept && (wr.wr_addr == LAST_ADDR);

    // Byte assembly, holding register, address counter and load FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_COLLECT;
            byte_idx    <= '0;
            partial     <= '0;
            wr.wr_valid <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (capture) begin
                partial  <= next_word;
                byte_idx <= complete ? '0 : byte_idx + IDX_W'(1);
            end else if (expire) begin
                partial  <= '0;
                byte_idx <= '0;
            end

            case (state)
                S_COLLECT: begin
                    if (final_accept) begin
                        // Last word leaves; any word completing now is discarded.
                        wr.wr_valid <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        // wr_addr tracks accepted words, so a word loaded alongside
                        // an acceptance picks up the incremented address.
                        if (accept) begin
                            wr.wr_addr <= wr.wr_addr + ADDR_W'(1);
                        end
                        if (complete) begin
                            if (!wr.wr_valid || wr.wr_ready) begin
                                wr.wr_data  <= next_word;
                                wr.wr_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else if (accept) begin
                            wr.wr_valid <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    wr.wr_valid <= 1'b0;
                end
                default: begin
                    state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader (WORD_BYTES=4, NUM_WORDS=4,
// TIMEOUT_CYCLES=50). Accepted words are checked against a scoreboard queue.
module tb_uart_word_loader;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned ADDR_W         = 10;
    localparam int unsigned NUM_WORDS      = 4;
    localparam int unsigned TIMEOUT_CYCLES = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [1:0] byte_idx;
    logic       done;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    uart_word_loader_if #(.ADDR_W(ADDR_W), .DATA_W(8 * WORD_BYTES)) wr_bus ();

    uart_word_loader #(
        .WORD_BYTES     (WORD_BYTES),
        .ADDR_W         (ADDR_W),
        .NUM_WORDS      (NUM_WORDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .wr       (wr_bus),
        .byte_idx (byte_idx),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t sb[$];

    typedef struct packed {
        logic [31:0] bytes;     // first byte sent in [7:0]
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [9:0]  exp_addr;
        logic        exp_done;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: every accepted word must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && wr_bus.wr_valid && wr_bus.wr_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_accept", 64'(wr_bus.wr_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_addr", 64'(wr_bus.wr_addr), 64'(e.addr));
                check("sb_data", 64'(wr_bus.wr_data), 64'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1 rx_dv = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1 check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        rx_dv = 1'b0;
        wr_bus.wr_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"},   64'(wr_bus.wr_valid), 64'd0);
        check({tag, "_addr"},    64'(wr_bus.wr_addr),  64'd0);
        check({tag, "_data"},    64'(wr_bus.wr_data),  64'd0);
        check({tag, "_idx"},     64'(byte_idx),        64'd0);
        check({tag, "_done"},    64'(done),            64'd0);
        check({tag, "_overrun"}, 64'(overrun),         64'd0);
    endtask

    initial begin
        vec_t vec [5];
        logic [31:0] wa, wb, wc;

        wr_bus.wr_ready = 1'b0;
        vec[0] = '{32'h00000013, 1'b1, 32'h00000013, 10'd0, 1'b0};
        vec[1] = '{32'h44332211, 1'b1, 32'h44332211, 10'd1, 1'b0};
        vec[2] = '{32'h00FF5AA5, 1'b1, 32'h00FF5AA5, 10'd2, 1'b0};
        vec[3] = '{32'hFE7F8001, 1'b1, 32'hFE7F8001, 10'd3, 1'b1};
        vec[4] = '{32'hEFBEADDE, 1'b0, 32'h0,        10'd0, 1'b1};

        // Reset state
        apply_reset();
        check_cleared("reset");

        // Full load of NUM_WORDS words plus one ignored word
        wr_bus.wr_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            if (vec[r].exp_valid) push_exp(vec[r].exp_addr, vec[r].exp_data);
            for (int k = 0; k < 4; k++) begin
                send_byte(vec[r].bytes[8*k +: 8]);
                check("tbl_byte_idx", 64'(byte_idx),
                      vec[r].exp_valid ? 64'((k + 1) % 4) : 64'd0);
            end
            check("tbl_valid", 64'(wr_bus.wr_valid), 64'(vec[r].exp_valid));
            if (vec[r].exp_valid) begin
                check("tbl_data", 64'(wr_bus.wr_data), 64'(vec[r].exp_data));
                check("tbl_addr", 64'(wr_bus.wr_addr), 64'(vec[r].exp_addr));
            end
            @(posedge clk);
            #1 check("tbl_done", 64'(done), 64'(vec[r].exp_done));
        end
        check("tbl_valid_after_done", 64'(wr_bus.wr_valid), 64'd0);
        drain("tbl_drain");

        // Overrun: held word stays stable, second word dropped
        apply_reset();
        wa = 32'h44332211;
        wb = 32'hCAFEF00D;
        wc = 32'h88776655;
        send_word(wa);
        check("ovr_valid", 64'(wr_bus.wr_valid), 64'd1);
        check("ovr_addr0", 64'(wr_bus.wr_addr), 64'd0);
        for (int k = 0; k < 4; k++) begin
            send_byte(wb[8*k +: 8]);
            check("ovr_held_data", 64'(wr_bus.wr_data), 64'(wa));
        end
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_held_addr", 64'(wr_bus.wr_addr), 64'd0);
        check("ovr_still_valid", 64'(wr_bus.wr_valid), 64'd1);
        push_exp(10'd0, wa);
        wr_bus.wr_ready = 1'b1;
        push_exp(10'd1, wc);
        send_word(wc);
        drain("ovr_drain");
        check("ovr_sticky", 64'(overrun), 64'd1);

        // Acceptance coinciding with completion of the next word
        apply_reset();
        wa = 32'h0BADBEEF;
        wb = 32'h12345678;
        push_exp(10'd0, wa);
        push_exp(10'd1, wb);
        send_word(wa);
        for (int k = 0; k < 3; k++) send_byte(wb[8*k +: 8]);
        @(posedge clk);
        #1 rx_dv = 1'b1;
        rx_byte = wb[31:24];
        wr_bus.wr_ready = 1'b1;
        @(posedge clk);
        #1 rx_dv = 1'b0;
        wr_bus.wr_ready = 1'b0;
        check("same_valid", 64'(wr_bus.wr_valid), 64'd1);
        check("same_data", 64'(wr_bus.wr_data), 64'(wb));
        check("same_addr", 64'(wr_bus.wr_addr), 64'd1);
        check("same_overrun", 64'(overrun), 64'd0);
        wr_bus.wr_ready = 1'b1;
        drain("same_drain");

        // Partial word after a long idle gap
        apply_reset();
        wr_bus.wr_ready = 1'b1;
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (60) @(posedge clk);
        #1;
`ifdef UART_LOADER_TIMEOUT_EN
        check("idle_idx", 64'(byte_idx), 64'd0);
        push_exp(10'd0, 32'hEFBEADDE);
`else
        check("idle_idx", 64'(byte_idx), 64'd2);
        push_exp(10'd0, 32'hADDE3412);
`endif
        send_word(32'hEFBEADDE);
        drain("idle_drain");
`ifdef UART_LOADER_TIMEOUT_EN
        check("idle_idx_end", 64'(byte_idx), 64'd0);
`else
        check("idle_idx_end", 64'(byte_idx), 64'd2);
`endif

        // Reset mid-word with a held word pending
        apply_reset();
        send_word(32'hA1A2A3A4);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("mid_idx", 64'(byte_idx), 64'd3);
        check("mid_valid", 64'(wr_bus.wr_valid), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_cleared("mid_rst");
        wr_bus.wr_ready = 1'b1;
        push_exp(10'd0, 32'h5566AABB);
        send_word(32'h5566AABB);
        drain("mid_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
